dut_host: RTL

DUT_HOST -- requirements
Module: dut_host

---
 rtl/dut_host.sv | 105 ++++++++++
 1 files changed

// File: rtl/dut_host.sv
// dut_host: handshake host that pushes an operand pair into a polled slave and returns one result bit
module dut_host #(
    parameter int POLL_LIMIT = 255
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_a,
    input  logic       req_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_y,
    output logic       rsp_err,
    output logic [2:0] write_address,
    output logic       write_data,
    output logic       write_en,
    input  logic       write_rdy,
    output logic [2:0] read_address,
    output logic       read_en,
    input  logic       read_data,
    input  logic       read_rdy,
    output logic [7:0] txn_count
);
    typedef enum logic [2:0] {IDLE, POLL_A, WR_A, POLL_B, WR_B, POLL_Y, RD_Y, RSP} state_t;

    localparam logic [7:0] LIMIT = 8'(POLL_LIMIT);

    state_t     r_state, w_next;
    logic       r_a, r_b, r_rsp_y, r_rsp_err;
    logic [7:0] r_poll, r_txn, w_poll_inc;
    logic       w_is_poll, w_poll_miss, w_timeout;

    assign w_is_poll   = (r_state == POLL_A) || (r_state == POLL_B) || (r_state == POLL_Y);
    assign w_poll_miss = w_is_poll && read_rdy && !read_data;
    assign w_poll_inc  = (r_poll == 8'hFF) ? r_poll : r_poll + 8'd1;
    assign w_timeout   = w_poll_miss && (w_poll_inc >= LIMIT);
    assign rsp_y       = r_rsp_y;
    assign rsp_err     = r_rsp_err;
    assign txn_count   = r_txn;

    // state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // next-state: polls only advance on a granted read, writes only on a granted write
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = POLL_A;
            POLL_A:  if (read_rdy) w_next = read_data ? WR_A : (w_timeout ? RSP : POLL_A);
            WR_A:    if (write_rdy) w_next = POLL_B;
            POLL_B:  if (read_rdy) w_next = read_data ? WR_B : (w_timeout ? RSP : POLL_B);
            WR_B:    if (write_rdy) w_next = POLL_Y;
            POLL_Y:  if (read_rdy) w_next = read_data ? RD_Y : (w_timeout ? RSP : POLL_Y);
            RD_Y:    if (read_rdy) w_next = RSP;
            RSP:     if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // outputs decoded from state; strobes gated by the slave ready
    always_comb begin
        req_ready     = (r_state == IDLE);
        rsp_valid     = (r_state == RSP);
        read_en       = (w_is_poll || (r_state == RD_Y)) && read_rdy;
        write_en      = ((r_state == WR_A) || (r_state == WR_B)) && write_rdy;
        read_address  = (r_state == POLL_B) ? 3'd1 :
                        (r_state == POLL_Y) ? 3'd2 :
                        (r_state == RD_Y)   ? 3'd3 : 3'd0;
        write_address = (r_state == WR_A) ? 3'd4 : (r_state == WR_B) ? 3'd5 : 3'd0;
        write_data    = (r_state == WR_A) ? r_a : (r_state == WR_B) ? r_b : 1'b0;
    end

    // operand latch, saturating poll counter, result and transaction count
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_a       <= 1'b0;
            r_b       <= 1'b0;
            r_poll    <= 8'd0;
            r_rsp_y   <= 1'b0;
            r_rsp_err <= 1'b0;
            r_txn     <= 8'd0;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_a    <= req_a;
                r_b    <= req_b;
                r_poll <= 8'd0;
            end
            if (write_en) r_poll <= 8'd0;
            if (w_poll_miss) r_poll <= w_poll_inc;
            if (w_timeout) begin
                r_rsp_y   <= 1'b0;
                r_rsp_err <= 1'b1;
            end
            if (r_state == RD_Y && read_rdy) begin
                r_rsp_y   <= read_data;
                r_rsp_err <= 1'b0;
            end
            if (r_state == RSP && rsp_ready) r_txn <= r_txn + 8'd1;
        end
    end
endmodule
